// File: rtl/fll_cfg_pkg.sv
// -----------------------------------------------------------------------------
// fll_cfg_pkg
// Shared definitions for the FLL configuration initiator:
//   - FSM state encoding
//   - APB register byte offsets (FLL registers 0..3 and STATUS)
//   - STATUS bit positions and the fll_wrn encoding for reads
//   - status_word(): packs lock / sticky timeout into the STATUS read value
// -----------------------------------------------------------------------------
package fll_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2,
        ST_RESP = 2'd3
    } fll_state_e;

    localparam logic [4:0] FLL_REG0    = 5'h00;
    localparam logic [4:0] FLL_REG1    = 5'h04;
    localparam logic [4:0] FLL_REG2    = 5'h08;
    localparam logic [4:0] FLL_REG3    = 5'h0C;
    localparam logic [4:0] STATUS_ADDR = 5'h10;

    localparam int STATUS_LOCK_BIT = 0;
    localparam int STATUS_TO_BIT   = 1;

    localparam logic FLL_WRN_READ = 1'b1;

    function automatic logic [31:0] status_word(input logic lock, input logic sticky_to);
        logic [31:0] w;
        w                  = '0;
        w[STATUS_LOCK_BIT] = lock;
        w[STATUS_TO_BIT]   = sticky_to;
        return w;
    endfunction

endpackage

// File: rtl/fll_cfg_sync.sv
// -----------------------------------------------------------------------------
// fll_cfg_sync
// Multi-flop synchroniser for a single asynchronous level signal.
// Ports:
//   clk_i  in   destination clock
//   rst_i  in   synchronous active-high reset, clears the whole chain
//   d_i    in   asynchronous input
//   q_o    out  synchronised output (SYNC_STAGES clk_i edges of latency)
// -----------------------------------------------------------------------------
module fll_cfg_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/fll_cfg_initiator.sv
// -----------------------------------------------------------------------------
// fll_cfg_initiator
// APB slave that turns each access into one 4-phase req/ack transaction on an
// FLL configuration port. ack and lock arrive from the FLL reference-clock
// domain and are synchronised here.
// Ports:
//   clk_i, rst_i                 block clock, synchronous active-high reset
//   psel_i, penable_i, pwrite_i  APB control
//   paddr_i, pwdata_i            APB byte address / write data
//   prdata_o, pready_o,
//   pslverr_o                    APB response (valid only while pready_o = 1)
//   fll_req_o, fll_wrn_o,
//   fll_add_o, fll_data_o        FLL config request side (wrn: 1 = read)
//   fll_ack_i, fll_r_data_i      FLL acknowledge (async) and read data
//   fll_lock_i, lock_o           FLL lock (async) and its synchronised copy
// Register map (word index paddr_i[.. :2]): 0..3 FLL registers, 4 STATUS
// (bit0 lock RO, bit1 sticky timeout W1C), anything above is an error.
// -----------------------------------------------------------------------------
module fll_cfg_initiator
    import fll_cfg_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]               pwdata_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic                      fll_req_o,
    output logic                      fll_wrn_o,
    output logic [1:0]                fll_add_o,
    output logic [31:0]               fll_data_o,
    input  logic                      fll_ack_i,
    input  logic [31:0]               fll_r_data_i,
    input  logic                      fll_lock_i,
    output logic                      lock_o
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam int               WORD_W   = APB_ADDR_WIDTH - 2;

    fll_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sticky_q, sticky_d;
    logic [1:0]        add_q, add_d;
    logic              wrn_q, wrn_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              req_q, req_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [31:0]       prdata_q, prdata_d;

    logic              ack_s;
    logic              lock_s;
    logic [WORD_W-1:0] word_idx;
    logic              access;
    logic              is_fll;
    logic              is_status;
    logic              busy;
    logic              timeout;
    logic              abort;
    logic              unused_addr_bits;

    fll_cfg_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (fll_ack_i),
        .q_o   (ack_s)
    );

    fll_cfg_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (fll_lock_i),
        .q_o   (lock_s)
    );

    // Byte lanes within a word are irrelevant to decoding.
    assign unused_addr_bits = ^paddr_i[1:0];

    assign word_idx  = paddr_i[APB_ADDR_WIDTH-1:2];
    assign is_fll    = (word_idx <= WORD_W'(FLL_REG3 >> 2));
    assign is_status = (word_idx == WORD_W'(STATUS_ADDR >> 2));
    assign access    = psel_i & penable_i;
    assign busy      = (state_q == ST_REQ) || (state_q == ST_REL);
    assign timeout   = busy && (cnt_q == CNT_LAST);

    // A timeout only aborts when the handshake phase has not completed in
    // that same cycle; a completing ack/release takes priority.
    assign abort = timeout &&
                   (((state_q == ST_REQ) && !ack_s) || ((state_q == ST_REL) && ack_s));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            add_q     <= '0;
            wrn_q     <= FLL_WRN_READ;
            data_q    <= '0;
            rdata_q   <= '0;
            req_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
            add_q     <= add_d;
            wrn_q     <= wrn_d;
            data_q    <= data_d;
            rdata_q   <= rdata_d;
            req_q     <= req_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (is_fll) begin
                        // A stale ack from an aborted handshake must clear
                        // before a new request may start.
                        if (!ack_s) state_d = ST_REQ;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_REQ: begin
                if (ack_s)        state_d = ST_REL;
                else if (timeout) state_d = ST_RESP;
            end
            ST_REL: begin
                if (!ack_s || timeout) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next-values
    always_comb begin
        cnt_d     = cnt_q;
        sticky_d  = sticky_q;
        add_d     = add_q;
        wrn_d     = wrn_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        req_d     = (state_d == ST_REQ);
        pready_d  = (state_d == ST_RESP);
        pslverr_d = 1'b0;
        prdata_d  = '0;

        // Counter restarts on any state change and saturates at the limit.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (busy && !timeout) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
            add_d  = paddr_i[3:2];
            wrn_d  = !pwrite_i;
            data_d = pwdata_i;
        end

        if ((state_q == ST_REQ) && ack_s && (wrn_q == FLL_WRN_READ)) begin
            rdata_d = fll_r_data_i;
        end

        // Set after clear so a coincident timeout wins over W1C.
        if ((state_q == ST_IDLE) && access && is_status && pwrite_i && pwdata_i[STATUS_TO_BIT]) begin
            sticky_d = 1'b0;
        end
        if (abort) begin
            sticky_d = 1'b1;
        end

        if (state_d == ST_RESP) begin
            unique case (state_q)
                ST_IDLE: begin
                    pslverr_d = !is_status;
                    if (is_status && !pwrite_i) prdata_d = status_word(lock_s, sticky_q);
                end
                ST_REL: begin
                    if (!abort && (wrn_q == FLL_WRN_READ)) prdata_d = rdata_q;
                end
                default: prdata_d = '0;
            endcase
            if (abort) pslverr_d = 1'b1;
        end
    end

    assign prdata_o   = prdata_q;
    assign pready_o   = pready_q;
    assign pslverr_o  = pslverr_q;
    assign fll_req_o  = req_q;
    assign fll_wrn_o  = wrn_q;
    assign fll_add_o  = add_q;
    assign fll_data_o = data_q;
    assign lock_o     = lock_s;

endmodule

// File: tb/tb_fll_cfg_initiator.sv
module tb_fll_cfg_initiator;

    localparam int AW = 12;
    localparam int TO = 16;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata, prdata;
    logic          pready, pslverr;
    logic          fll_req, fll_wrn;
    logic [1:0]    fll_add;
    logic [31:0]   fll_data, fll_r_data;
    logic          fll_ack = 1'b0;
    logic          fll_lock;
    logic          lock;

    always #5 clk = ~clk;

    fll_cfg_initiator #(
        .APB_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (SS)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .psel_i       (psel),
        .penable_i    (penable),
        .pwrite_i     (pwrite),
        .paddr_i      (paddr),
        .pwdata_i     (pwdata),
        .prdata_o     (prdata),
        .pready_o     (pready),
        .pslverr_o    (pslverr),
        .fll_req_o    (fll_req),
        .fll_wrn_o    (fll_wrn),
        .fll_add_o    (fll_add),
        .fll_data_o   (fll_data),
        .fll_ack_i    (fll_ack),
        .fll_r_data_i (fll_r_data),
        .fll_lock_i   (fll_lock),
        .lock_o       (lock)
    );

    // FLL model: ack echoes req through one flop; registers stored on write.
    // no_ack suppresses ack entirely; cyc < rel_cyc forces a stray late ack.
    int          cyc     = 0;
    int          rel_cyc = 0;
    logic        no_ack  = 1'b0;
    logic [31:0] mem [4] = '{default: 32'h0};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (no_ack)              fll_ack <= 1'b0;
        else if (cyc < rel_cyc)  fll_ack <= 1'b1;
        else                     fll_ack <= fll_req;
        if (fll_req && !fll_wrn && !no_ack) mem[fll_add] <= fll_data;
    end

    assign fll_r_data = mem[fll_add];

    // Reference state of the register file as seen from the APB side.
    logic [31:0] ref_regs [4] = '{default: 32'h0};
    logic        ref_sticky = 1'b0;
    logic        ref_lock   = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] x_rd;
    logic        x_err, x_done, x_hold_bad, x_req_end;
    int          x_waits, x_end_cyc, x_req_cyc;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [31:0]   wd;
        logic [31:0]   rd;
        logic          chk_rd;
        logic          err;
        int            waits;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic apb_xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wd);
        logic [1:0] ea;
        logic       started;
        ea = addr[3:2];
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
        @(negedge clk);
        penable    = 1'b1;
        x_waits    = 0;
        x_done     = 1'b0;
        x_hold_bad = 1'b0;
        x_req_cyc  = -1;
        x_end_cyc  = 0;
        x_rd       = '0;
        x_err      = 1'b0;
        x_req_end  = 1'b0;
        started    = 1'b0;
        while (!x_done && x_waits < 400) begin
            @(negedge clk);
            x_waits++;
            if (fll_req && !started) begin
                started   = 1'b1;
                x_req_cyc = cyc;
            end
            if (started && (fll_add !== ea || fll_wrn !== !wr || fll_data !== wd)) x_hold_bad = 1'b1;
            if (pready) begin
                x_done    = 1'b1;
                x_rd      = prdata;
                x_err     = pslverr;
                x_end_cyc = cyc;
                x_req_end = fll_req;
            end
        end
        psel = 1'b0; penable = 1'b0;
        n_cmp++;
        if (!x_done) begin
            n_fail++;
            $display("FAIL xfer_done addr=0x%03h: no pready within %0d cycles, required pready", addr, x_waits);
        end
    endtask

    task automatic run_vec(input string nm, input logic [AW-1:0] addr, input logic wr,
                           input logic [31:0] wd, input logic [31:0] exp_rd, input logic chk_rd,
                           input logic exp_err, input int exp_waits);
        apb_xfer(addr, wr, wd);
        if (x_done) begin
            chk({nm, "_err"},   32'(x_err),   32'(exp_err));
            chk({nm, "_waits"}, 32'(x_waits), 32'(exp_waits));
            if (chk_rd) chk({nm, "_rdata"}, x_rd, exp_rd);
            if (addr < AW'('h10)) begin
                chk({nm, "_req_seen"}, 32'(x_req_cyc >= 0), 32'd1);
                chk({nm, "_hold"},     32'(x_hold_bad),     32'd0);
            end else begin
                chk({nm, "_no_req"},   32'(x_req_cyc >= 0), 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a;
        logic          w;
        logic [31:0]   d, er;
        logic          ee;
        int            ew, sel;
        logic [1:0]    idx;

        vecs[0]  = '{12'h004, 1'b1, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 9};
        vecs[1]  = '{12'h004, 1'b0, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 9};
        vecs[2]  = '{12'h00C, 1'b1, 32'h12345678, 32'h0,        1'b0, 1'b0, 9};
        vecs[3]  = '{12'h00C, 1'b0, 32'h0,        32'h12345678, 1'b1, 1'b0, 9};
        vecs[4]  = '{12'h00E, 1'b0, 32'h0,        32'h12345678, 1'b1, 1'b0, 9};
        vecs[5]  = '{12'h000, 1'b1, 32'hA5A50F0F, 32'h0,        1'b0, 1'b0, 9};
        vecs[6]  = '{12'h000, 1'b0, 32'h0,        32'hA5A50F0F, 1'b1, 1'b0, 9};
        vecs[7]  = '{12'h008, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 9};
        vecs[8]  = '{12'h010, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1};
        vecs[9]  = '{12'h013, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1};
        vecs[10] = '{12'h020, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 1};
        vecs[11] = '{12'h014, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b1, 1};
        vecs[12] = '{12'hFFC, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 1};

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; fll_lock = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_prdata",  prdata,          32'h0);
        chk("rst_pready",  32'(pready),     32'h0);
        chk("rst_pslverr", 32'(pslverr),    32'h0);
        chk("rst_req",     32'(fll_req),    32'h0);
        chk("rst_wrn",     32'(fll_wrn),    32'h1);
        chk("rst_add",     32'(fll_add),    32'h0);
        chk("rst_data",    fll_data,        32'h0);
        chk("rst_lock",    32'(lock),       32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].wd,
                    vecs[i].rd, vecs[i].chk_rd, vecs[i].err, vecs[i].waits);
        end
        ref_regs[0] = 32'hA5A50F0F;
        ref_regs[1] = 32'hDEADBEEF;
        ref_regs[3] = 32'h12345678;

        // Timeout: FLL never acknowledges.
        no_ack = 1'b1;
        apb_xfer(12'h008, 1'b1, 32'hCAFEF00D);
        chk("to_err",        32'(x_err),     32'h1);
        chk("to_req_dropped", 32'(x_req_end), 32'h0);
        chk("to_waits_range", 32'(x_waits >= TO && x_waits <= TO + 2), 32'h1);
        no_ack = 1'b0;
        ref_sticky = 1'b1;
        run_vec("to_status", 12'h010, 1'b0, 32'h0, 32'h2, 1'b1, 1'b0, 1);
        run_vec("to_w1c",    12'h010, 1'b1, 32'h2, 32'h0, 1'b0, 1'b0, 1);
        ref_sticky = 1'b0;
        run_vec("to_status_clr", 12'h010, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1);

        // Late ack after a timeout, then an access while the stale ack is seen.
        no_ack = 1'b1;
        apb_xfer(12'h004, 1'b0, 32'h0);
        chk("late_to_err", 32'(x_err), 32'h1);
        no_ack  = 1'b0;
        rel_cyc = cyc + 12;
        repeat (4) @(negedge clk);
        apb_xfer(12'h004, 1'b1, 32'h0BADF00D);
        chk("late_err",     32'(x_err),      32'h0);
        chk("late_req_cyc", 32'(x_req_cyc),  32'(rel_cyc + 4));
        chk("late_end_cyc", 32'(x_end_cyc),  32'(rel_cyc + 12));
        chk("late_hold",    32'(x_hold_bad), 32'h0);
        ref_regs[1] = 32'h0BADF00D;
        run_vec("late_rd",     12'h004, 1'b0, 32'h0, 32'h0BADF00D, 1'b1, 1'b0, 9);
        run_vec("late_status", 12'h010, 1'b0, 32'h0, 32'h2,        1'b1, 1'b0, 1);
        run_vec("late_w1c",    12'h010, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1);

        // Lock synchroniser.
        @(negedge clk);
        fll_lock = 1'b1;
        @(negedge clk);
        chk("lock_1cyc", 32'(lock), 32'h0);
        @(negedge clk);
        chk("lock_2cyc", 32'(lock), 32'h1);
        ref_lock = 1'b1;
        run_vec("lock_status", 12'h010, 1'b0, 32'h0, 32'h1, 1'b1, 1'b0, 1);

        // Randomised transactions against the reference register file.
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)      a = AW'($urandom_range(0, 15));
            else if (sel < 8) a = AW'($urandom_range(16, 19));
            else              a = AW'($urandom_range(20, 4095));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (a < AW'('h10)) begin
                idx = a[3:2];
                er  = ref_regs[idx];
                ee  = 1'b0;
                ew  = 9;
                if (w) ref_regs[idx] = d;
            end else if (a < AW'('h14)) begin
                er = {30'h0, ref_sticky, ref_lock};
                ee = 1'b0;
                ew = 1;
                if (w && d[1]) ref_sticky = 1'b0;
            end else begin
                er = 32'h0;
                ee = 1'b1;
                ew = 1;
            end
            run_vec($sformatf("rnd%0d", i), a, w, d, er, !w, ee, ew);
        end

        // Reset while the request is outstanding.
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = 12'h008; pwrite = 1'b1; pwdata = 32'h77771234;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        chk("rreq_req_before", 32'(fll_req), 32'h1);
        chk("rreq_wrn_before", 32'(fll_wrn), 32'h0);
        rst = 1'b1; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("rreq_req",    32'(fll_req), 32'h0);
        chk("rreq_pready", 32'(pready),  32'h0);
        chk("rreq_wrn",    32'(fll_wrn), 32'h1);
        chk("rreq_data",   fll_data,     32'h0);
        rst = 1'b0;
        // The FLL saw one cycle of a write request and took the data.
        ref_regs[2] = 32'h77771234;
        repeat (8) @(negedge clk);
        run_vec("rreq_after", 12'h008, 1'b0, 32'h0, 32'h77771234, 1'b1, 1'b0, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
